mb_addsub_seq: RTL and testbench
================================

Name: mb_addsub_seq

Overview:
- Multi-byte add/subtract sequencer built around one shared 8-bit add/sub slice with carry lookahead.
- Processes an NBYTES-wide operation one byte per cycle, LSB byte first, and chains the carry between bytes in a register.
- Trades latency for area: wide arithmetic is possible without replicating wide carry-lookahead logic.
- Sits between a register-file/ALU front end and the byte datapath.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand (legal range 2..16); W = 8*NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only while ready=1.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- opa  input  W  operand A; sampled with start.
- opb  input  W  operand B; sampled with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when result, carry_out and overflow are valid.
- result  output  W  sum or difference.
- carry_out  output  1  carry out of the MSB. For subtract, 1 means no borrow (A >= B unsigned).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Byte slice:
  - s = a + (b XOR {8{sub}}) + cin, producing an 8-bit sum and a cout.
  - The slice is purely combinational and is instantiated once.
- Reset (rst=1 at a clock edge):
  - state=IDLE, ready=1, done=0.
  - result=0, carry_out=0, overflow=0.
  - Internal byte index, carry register and operand registers are cleared.
  - Reset overrides every other input, including reset in the middle of an operation: the operation is abandoned and no done is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - ready=1.
  - When start=1: latch opa, opb and op_sub; idx<=0; carry<=op_sub; state<=RUN.
  - Otherwise hold.
- RUN:
  - ready=0.
  - Each cycle the slice computes byte idx using a=opa_r[8*idx+:8], b=opb_r[8*idx+:8], cin=carry.
  - result[8*idx+:8] <= slice sum; carry <= slice cout; idx <= idx+1.
  - When idx==NBYTES-1, the same edge also does:
    - carry_out <= slice cout.
    - overflow <= (a[7] == b'[7]) && (sum[7] != a[7]), where b' = b XOR {8{op_sub}}, all on the MSB byte.
    - state <= FIN.
- FIN:
  - done=1 for exactly this one cycle; ready=0.
  - Next state is IDLE.
  - start is ignored in FIN.
- Latency:
  - Start accepted at edge T0 → done high in the cycle after edge T0+NBYTES.
  - For NBYTES=4, done appears 5 cycles after start is sampled.
  - Next start can be accepted at edge T0+NBYTES+2, giving throughput of one operation per NBYTES+2 cycles.
- Output holding:
  - result, carry_out and overflow hold their values until the next accepted start.
  - result bytes update progressively during RUN; they are valid only when done=1 and afterwards.
  - carry_out and overflow change only on the last RUN edge.
- Input stability: operand inputs may change freely after start is accepted, because the block uses only the latched copies.
- start while ready=0: ignored. It is not queued and is not acknowledged later.
- Wrap-around: add/subtract is modulo 2^W. Only carry_out and overflow report the excess.
- Identities:
  - Subtract of equal operands gives result=0, carry_out=1, overflow=0.
  - Add of 0+0 gives all outputs 0.

Test Plan:
- Add with cross-byte carry: NBYTES=4, start with op_sub=0, opa=0x000000FF, opb=0x00000001 → ready low for 5 cycles; done pulses exactly 5 cycles after start; result=0x00000100, carry_out=0, overflow=0.
- Full carry ripple: add 0xFFFFFFFF + 0x00000001 → result=0x00000000, carry_out=1, overflow=0. Then sub 0x00000000 − 0x00000001 → result=0xFFFFFFFF, carry_out=0, overflow=0.
- Signed overflow:
  - add 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow=1, carry_out=0.
  - sub 0x80000000 − 0x00000001 → 0x7FFFFFFF, overflow=1, carry_out=1.
  - sub 0x12345678 − 0x12345678 → 0, carry_out=1, overflow=0.
- Handshake: hold start=1 continuously with changing operands → only operations started while ready=1 execute; done never lasts more than 1 cycle; changing opa mid-RUN does not alter result; back-to-back operations are spaced 6 cycles apart.
- Reset mid-operation: assert rst on the 2nd RUN cycle → next cycle has ready=1, done=0, result=0, carry_out=0, overflow=0, and no done pulse follows. A fresh add 0x00000002 + 0x00000003 then completes with result 0x00000005.
- Parameter sweep: NBYTES=2, add 0xFFFF + 0x0001 → result 0x0000, carry_out=1, done 3 cycles after start.

Source files
------------

// File: rtl/mb_addsub_seq.sv
// rtl/mb_addsub_seq.sv - multi-byte add/subtract sequencer sharing one 8-bit lookahead slice

// Purely combinational 8-bit add/sub slice: sum = a + (b ^ {8{sub}}) + cin.
module mb_addsub_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] bx;
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Each carry is a flat sum of products of generate/propagate terms and cin,
    // so no carry depends on a previously computed carry.
    always_comb begin
        logic term;
        logic acc;
        bx = b ^ {8{sub}};
        g  = a & bx;
        p  = a ^ bx;
        c  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = acc | term;
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// Sequencer: one byte per cycle, LSB first, carry chained through a register.
module mb_addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op_sub,
    input  logic [8*NBYTES-1:0] opa,
    input  logic [8*NBYTES-1:0] opb,
    output logic                ready,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                overflow
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_out_q, carry_out_d;
    logic            overflow_q, overflow_d;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      sum_byte;
    logic            slice_cout;
    logic            last_byte;

    mb_addsub_slice u_slice (
        .a    (a_byte),
        .b    (b_byte),
        .sub  (sub_q),
        .cin  (carry_q),
        .sum  (sum_byte),
        .cout (slice_cout)
    );

    // Select the operand bytes addressed by the current byte index.
    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                a_byte = opa_q[8*i +: 8];
                b_byte = opb_q[8*i +: 8];
            end
        end
        last_byte = (idx_q == IW'(NBYTES - 1));
    end

    // State register and datapath flops; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> FIN after the MSB byte, FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_byte) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch operands on accept, fold one byte per RUN cycle.
    always_comb begin
        idx_d       = idx_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = opa;
                    opb_d   = opb;
                    sub_d   = op_sub;
                    idx_d   = '0;
                    // Subtract is A + ~B + 1, so the initial carry supplies the +1.
                    carry_d = op_sub;
                end
            end
            RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[8*i +: 8] = sum_byte;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    carry_out_d = slice_cout;
                    overflow_d  = (a_byte[7] == (b_byte[7] ^ sub_q)) &&
                                  (sum_byte[7] != a_byte[7]);
                end
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        ready     = (state_q == IDLE);
        done      = (state_q == FIN);
        result    = result_q;
        carry_out = carry_out_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_mb_addsub_seq.sv
// tb/tb_mb_addsub_seq.sv - self-checking bench for mb_addsub_seq (NBYTES=4 and NBYTES=2)
module tb_mb_addsub_seq;

    localparam int N4 = 4;
    localparam int N2 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0;
    logic        sub4 = 1'b0;
    logic [31:0] opa4 = '0;
    logic [31:0] opb4 = '0;
    logic        ready4, done4, cout4, ovf4;
    logic [31:0] res4;

    logic        start2 = 1'b0;
    logic        sub2 = 1'b0;
    logic [15:0] opa2 = '0;
    logic [15:0] opb2 = '0;
    logic        ready2, done2, cout2, ovf2;
    logic [15:0] res2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mb_addsub_seq #(.NBYTES(N4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_sub(sub4), .opa(opa4), .opb(opb4),
        .ready(ready4), .done(done4), .result(res4), .carry_out(cout4), .overflow(ovf4)
    );

    mb_addsub_seq #(.NBYTES(N2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_sub(sub2), .opa(opa2), .opb(opb2),
        .ready(ready2), .done(done2), .result(res2), .carry_out(cout2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model for the 4-byte instance: wide arithmetic plus a busy countdown.
    int          m_busy = 0;
    logic [31:0] m_res = '0, p_res = '0;
    logic        m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        logic [32:0] full;
        if (rst) begin
            m_busy = 0;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_busy == 0) begin
            if (start4) begin
                if (sub4) begin
                    full  = {1'b0, opa4} - {1'b0, opb4};
                    p_cout = (opa4 >= opb4);
                    p_res  = full[31:0];
                    p_ovf  = ($signed(opa4) < 0) != ($signed(opb4) < 0) &&
                             (p_res[31] != opa4[31]);
                end else begin
                    full  = {1'b0, opa4} + {1'b0, opb4};
                    p_cout = full[32];
                    p_res  = full[31:0];
                    p_ovf  = (opa4[31] == opb4[31]) && (p_res[31] != opa4[31]);
                end
                m_busy = N4 + 1;
            end
        end else begin
            m_busy = m_busy - 1;
            if (m_busy == 1) begin
                m_res  = p_res;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end
    end

    bit hold_mode = 1'b0;
    int last_done = -1;
    int prev_done = 0;

    // Per-cycle compare of the 4-byte instance against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", ready4, m_busy == 0);
            check("done", done4, m_busy == 1);
            check("carry_out_hold", cout4, m_cout);
            check("overflow_hold", ovf4, m_ovf);
            if (m_busy <= 1) check("result", res4, m_res);
            if (done4 && prev_done) check("done_width", 2, 1);
            if (done4 && hold_mode) begin
                if (last_done >= 0) check("b2b_spacing", cyc - last_done, 6);
                last_done = cyc;
            end
        end
        prev_done = done4;
    end

    // Run one 4-byte op with hand-computed expectations and a latency check.
    task automatic run4(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic ev, input string tag);
        int t0;
        int n;
        @(negedge clk);
        start4 = 1'b1; sub4 = s; opa4 = a; opb4 = b;
        t0 = cyc;
        @(negedge clk);
        start4 = 1'b0; opa4 = ~a; opb4 = 32'h5A5A_5A5A;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done4) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, cyc - t0, N4 + 1);
            check({tag, "_result"}, res4, er);
            check({tag, "_carry"}, cout4, ec);
            check({tag, "_ovf"}, ovf4, ev);
        end
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready4, 1);
        check("rst_done", done4, 0);
        check("rst_result", res4, 0);
        check("rst_carry", cout4, 0);
        check("rst_ovf", ovf4, 0);
        check("rst2_ready", ready2, 1);
        check("rst2_result", res2, 0);
        chk_en = 1'b1;
        rst = 1'b0;

        run4(1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, "add_carry");
        run4(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "add_ripple");
        run4(1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");
        run4(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        run4(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        run4(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, "sub_equal");
        run4(1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "add_zero");

        // Start held high with operands changing every cycle.
        hold_mode = 1'b1;
        last_done = -1;
        @(negedge clk);
        start4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sub4 = i[0];
            opa4 = $urandom;
            opb4 = $urandom;
            @(negedge clk);
        end
        start4 = 1'b0;
        n = 0;
        while (!ready4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_drain", ready4, 1);
        hold_mode = 1'b0;

        // Reset asserted during the second RUN cycle.
        @(negedge clk);
        start4 = 1'b1; sub4 = 1'b0; opa4 = 32'h0000_0010; opb4 = 32'h0000_0020;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", ready4, 1);
        check("midrst_done", done4, 0);
        check("midrst_result", res4, 0);
        check("midrst_carry", cout4, 0);
        check("midrst_ovf", ovf4, 0);
        repeat (8) @(negedge clk);
        run4(1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, "after_rst");

        // Two-byte instance.
        @(negedge clk);
        start2 = 1'b1; sub2 = 1'b0; opa2 = 16'hFFFF; opb2 = 16'h0001;
        t0 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done2) begin
            check("n2_timeout", 0, 1);
        end else begin
            check("n2_latency", cyc - t0, N2 + 1);
            check("n2_result", res2, 16'h0000);
            check("n2_carry", cout2, 1);
            check("n2_ovf", ovf2, 0);
        end
        @(negedge clk);
        check("n2_done_pulse", done2, 0);
        check("n2_ready", ready2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
